// File: rtl/cpu_core_param.sv
// rtl/cpu_core_param.sv - parametrised multicycle accumulator CPU core with synchronous RAM port
module cpu_core_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_re,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic [DATA_WIDTH-1:0] o_out,
    output logic                  o_out_valid,
    output logic                  o_flag_c,
    output logic                  o_flag_z,
    output logic                  o_halted
);
    typedef enum logic [2:0] {
        S_FETCH,
        S_LOAD_IR,
        S_DECODE,
        S_MEM_WAIT,
        S_EXEC,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [DATA_WIDTH-1:0]   r_ir;
    logic [DATA_WIDTH-1:0]   r_out;
    logic                    r_c;
    logic                    r_z;
    logic                    r_out_pend;

    logic [3:0]              w_op;
    logic [ADDR_WIDTH-1:0]   w_arg;
    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH:0]     w_diff;
    logic [DATA_WIDTH-1:0]   w_res;
    logic                    w_carry;
    logic                    w_re;
    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_addr;

    assign w_op  = r_ir[DATA_WIDTH-1 -: 4];
    assign w_arg = r_ir[ADDR_WIDTH-1:0];

    generate
        if (DATA_WIDTH > 4 + ADDR_WIDTH) begin : g_mid
            logic w_mid_unused;
            assign w_mid_unused = ^r_ir[DATA_WIDTH-5:ADDR_WIDTH];
        end
    endgenerate

    // Top bit of the difference is the borrow; carry flag stores its inverse.
    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
    assign w_res   = (w_op == OP_SUB) ? w_diff[DATA_WIDTH-1:0] : w_sum[DATA_WIDTH-1:0];
    assign w_carry = (w_op == OP_SUB) ? ~w_diff[DATA_WIDTH] : w_sum[DATA_WIDTH];

    always_comb begin
        w_next = r_state;
        w_re   = 1'b0;
        w_we   = 1'b0;
        w_addr = r_pc;
        case (r_state)
            S_FETCH: begin
                w_re   = 1'b1;
                w_next = S_LOAD_IR;
            end
            S_LOAD_IR: w_next = S_DECODE;
            S_DECODE: begin
                w_addr = w_arg;
                case (w_op)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        w_re   = 1'b1;
                        w_next = S_MEM_WAIT;
                    end
                    OP_STA: begin
                        w_we   = 1'b1;
                        w_next = S_FETCH;
                    end
                    OP_HLT:  w_next = S_HALTED;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM_WAIT: w_next = (w_op == OP_LDA) ? S_FETCH : S_EXEC;
            S_EXEC:     w_next = S_FETCH;
            S_HALTED:   w_next = S_HALTED;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_FETCH;
            r_pc       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_ir       <= '0;
            r_out      <= '0;
            r_c        <= 1'b0;
            r_z        <= 1'b0;
            r_out_pend <= 1'b0;
        end else if (i_enable) begin
            r_state    <= w_next;
            r_out_pend <= (r_state == S_DECODE) && (w_op == OP_OUT);
            case (r_state)
                S_LOAD_IR: begin
                    r_ir <= i_mem_rdata;
                    r_pc <= r_pc + ADDR_WIDTH'(1);
                end
                S_DECODE: begin
                    case (w_op)
                        OP_LDI:  r_a <= {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, w_arg};
                        OP_JMP:  r_pc <= w_arg;
                        OP_JC:   if (r_c) r_pc <= w_arg;
                        OP_JZ:   if (r_z) r_pc <= w_arg;
                        OP_OUT:  r_out <= r_a;
                        default: ;
                    endcase
                end
                S_MEM_WAIT: begin
                    if (w_op == OP_LDA) r_a <= i_mem_rdata;
                    else                r_b <= i_mem_rdata;
                end
                S_EXEC: begin
                    r_a <= w_res;
                    r_c <= w_carry;
                    r_z <= (w_res == '0);
                end
                default: ;
            endcase
        end
    end

    // A pending out pulse survives a stall and shows once enable returns.
    assign o_mem_addr  = w_addr;
    assign o_mem_re    = w_re & i_enable & ~i_reset;
    assign o_mem_we    = w_we & i_enable & ~i_reset;
    assign o_mem_wdata = r_a;
    assign o_out       = r_out;
    assign o_out_valid = r_out_pend & i_enable & ~i_reset;
    assign o_flag_c    = r_c;
    assign o_flag_z    = r_z;
    assign o_halted    = (r_state == S_HALTED);
endmodule

// File: tb/tb_cpu_core_param.sv
// tb/tb_cpu_core_param.sv - bench for cpu_core_param against an instruction-level model
module tb_cpu_core_param;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] out;
    logic          out_valid;
    logic          flag_c;
    logic          flag_z;
    logic          halted;

    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] ram [DEPTH];

    int checks = 0;
    int errors = 0;

    int prog  [DEPTH];
    int m_mem [DEPTH];
    int m_pc, m_a, m_c, m_z, m_out, m_total, m_halted, m_writes;
    int ev_cyc[$];
    int ev_val[$];

    int d_cyc[$];
    int d_val[$];
    int d_writes, halt_first, halt_wall, wall;

    always #5 clk = ~clk;

    cpu_core_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_enable   (enable),
        .o_mem_addr (mem_addr),
        .o_mem_re   (mem_re),
        .o_mem_we   (mem_we),
        .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata),
        .o_out      (out),
        .o_out_valid(out_valid),
        .o_flag_c   (flag_c),
        .o_flag_z   (flag_z),
        .o_halted   (halted)
    );

    // Synchronous RAM: output holds whenever no read is requested.
    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) prog[i] = 0;
    endtask

    // Instruction-level model: whole instructions at a time, with the cycle cost of each.
    task automatic model_run(input int budget);
        int op, arg, v, lat;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = prog[i];
        m_pc = 0; m_a = 0; m_c = 0; m_z = 0; m_out = 0;
        m_total = 0; m_halted = 0; m_writes = 0;
        ev_cyc.delete();
        ev_val.delete();
        while (m_halted == 0 && m_total < budget) begin
            op   = m_mem[m_pc] / 16;
            arg  = m_mem[m_pc] % 16;
            m_pc = (m_pc + 1) % DEPTH;
            lat  = 3;
            case (op)
                1: begin m_a = m_mem[arg]; lat = 4; end
                2: begin
                    v = m_a + m_mem[arg];
                    m_c = (v > 255) ? 1 : 0;
                    m_a = v % 256;
                    m_z = (m_a == 0) ? 1 : 0;
                    lat = 5;
                end
                3: begin
                    m_c = (m_a >= m_mem[arg]) ? 1 : 0;
                    m_a = (m_a - m_mem[arg] + 256) % 256;
                    m_z = (m_a == 0) ? 1 : 0;
                    lat = 5;
                end
                4: begin m_mem[arg] = m_a; m_writes++; end
                5: m_a = arg;
                6: m_pc = arg;
                7: if (m_c != 0) m_pc = arg;
                8: if (m_z != 0) m_pc = arg;
                15: m_halted = 1;
                default: ;
            endcase
            m_total += lat;
            if (op == 14) begin
                m_out = m_a;
                ev_cyc.push_back(m_total);
                ev_val.push_back(m_a);
            end
        end
    endtask

    task automatic start();
        reset = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_en = 1'b1; ld_addr = AW'(i); ld_data = DW'(prog[i]);
            @(posedge clk); #1;
        end
        ld_en = 1'b0;
        @(negedge clk);
        check("rst_out", int'(out), 0);
        check("rst_flags", int'({flag_c, flag_z}), 0);
        check("rst_status", int'({halted, out_valid, mem_re, mem_we}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic sample(input int e, input logic en);
        if (out_valid) begin d_cyc.push_back(e); d_val.push_back(int'(out)); end
        if (mem_we) d_writes++;
        if (halted && halt_first < 0) begin halt_first = e; halt_wall = wall; end
        if (!en) check("stall_quiet", int'({mem_re, mem_we, out_valid}), 0);
    endtask

    task automatic dut_run(input int n, input int s0, input int l0, input int s1, input int l1);
        int e, left0, left1;
        logic en;
        e = 0; left0 = l0; left1 = l1; wall = 0;
        d_cyc.delete(); d_val.delete(); d_writes = 0; halt_first = -1; halt_wall = -1;
        while (e < n && wall < 2000) begin
            en = 1'b1;
            if (e == s0 && left0 > 0) begin en = 1'b0; left0--; end
            else if (e == s1 && left1 > 0) begin en = 1'b0; left1--; end
            enable = en;
            @(negedge clk);
            sample(e, en);
            @(posedge clk); #1;
            if (en) e++;
            wall++;
        end
        if (wall >= 2000) check("run_budget", wall, -1);
    endtask

    task automatic finish_and_compare();
        int n;
        enable = 1'b1;
        @(negedge clk);
        sample(m_total, 1'b1);
        check("ev_count", d_cyc.size(), ev_cyc.size());
        n = (d_cyc.size() < ev_cyc.size()) ? d_cyc.size() : ev_cyc.size();
        for (int i = 0; i < n; i++) begin
            check("ev_cycle", d_cyc[i], ev_cyc[i]);
            check("ev_value", d_val[i], ev_val[i]);
        end
        check("writes", d_writes, m_writes);
        check("flag_c", int'(flag_c), m_c);
        check("flag_z", int'(flag_z), m_z);
        check("out_reg", int'(out), m_out);
        check("halt_first", halt_first, (m_halted != 0) ? m_total : -1);
        if (m_halted == 0) check("fetch_pc", int'(mem_addr), m_pc);
        for (int i = 0; i < DEPTH; i++) check("ram", int'(ram[i]), m_mem[i]);
        if (m_halted != 0) begin
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("halt_hold", int'({halted, mem_re, mem_we, out_valid}), 8);
            end
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("rst_no_strobe", int'({mem_re, mem_we}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_after_out", int'(out), 0);
        check("rst_after_flags", int'({flag_c, flag_z, halted, out_valid}), 0);
        check("rst_after_fetch", int'({mem_re, mem_addr}), 16);
        enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic load_add_prog();
        clear_prog();
        prog[0] = 'h1E; prog[1] = 'h2F; prog[2] = 'hE0; prog[3] = 'hF0;
        prog[14] = 'h1C; prog[15] = 'h0E;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        load_add_prog();
        start();
        model_run(200);
        dut_run(m_total, -1, 0, -1, 0);
        finish_and_compare();
        check("add_out", int'(out), 'h2A);
        check("add_pulses", d_cyc.size(), 1);
        check("add_halt_cycle", halt_first, 15);
        check("add_flags", int'({flag_c, flag_z}), 0);

        reset_pulse();
        dut_run(m_total, -1, 0, -1, 0);
        finish_and_compare();

        start();
        dut_run(8, -1, 0, -1, 0);
        reset_pulse();
        model_run(200);
        dut_run(m_total, -1, 0, -1, 0);
        finish_and_compare();
        check("midadd_out", int'(out), 'h2A);

        start();
        model_run(200);
        dut_run(m_total, 7, 4, 12, 4);
        finish_and_compare();
        check("stall_out", int'(out), 'h2A);
        check("stall_halt_cycle", halt_first, 15);
        check("stall_halt_wall", halt_wall, 23);

        clear_prog();
        prog[0] = 'h55; prog[1] = 'h3F; prog[2] = 'h70; prog[3] = 'hE0; prog[4] = 'hF0;
        prog[15] = 'h07;
        start();
        model_run(200);
        dut_run(m_total, -1, 0, -1, 0);
        finish_and_compare();
        check("sub_out", int'(out), 'hFE);
        check("sub_flags", int'({flag_c, flag_z}), 0);
        check("sub_pulses", d_cyc.size(), 1);

        clear_prog();
        prog[0] = 'h53; prog[1] = 'h3F; prog[2] = 'h86; prog[3] = 'hF0;
        prog[6] = 'hE0; prog[7] = 'hF0; prog[15] = 'h03;
        start();
        model_run(200);
        dut_run(m_total, -1, 0, -1, 0);
        finish_and_compare();
        check("jz_out", int'(out), 0);
        check("jz_flags", int'({flag_c, flag_z}), 3);
        check("jz_pulses", d_cyc.size(), 1);

        clear_prog();
        prog[0] = 'h59; prog[1] = 'h4D;
        start();
        model_run(51);
        dut_run(m_total, -1, 0, -1, 0);
        finish_and_compare();
        check("sta_ram13", int'(ram[13]), 9);
        check("sta_writes", d_writes, 1);
        check("wrap_pc", int'(mem_addr), 1);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < DEPTH; i++) prog[i] = int'($urandom_range(0, 255));
            start();
            model_run(120);
            dut_run(m_total, int'($urandom_range(0, 60)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 60)), int'($urandom_range(0, 3)));
            finish_and_compare();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_core_param.md
Name: cpu_core_param

Overview:
- Parametrised successor to the 8-bit bus CPU, built as a single-clock multicycle core.
- Accumulator A, operand register B, instruction register IR, program counter PC, C/Z flags and an output register.
- Internal datapath uses muxes; there is no shared tri-state bus.
- Talks to an external synchronous RAM through a simple read/write port. Replaces clock-gated halting with an enable input and a halted status output.

Parameters:
- DATA_WIDTH, 8, word width of A, B, IR, memory data and output. Must satisfy DATA_WIDTH >= 4 + ADDR_WIDTH.
- ADDR_WIDTH, 4, width of PC and memory address. Memory depth is 2^ADDR_WIDTH.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous reset, active-high.
- i_enable  in  1  when 0, all state and registers hold and memory strobes are forced to 0.
- o_mem_addr  out  ADDR_WIDTH  memory address.
- o_mem_re  out  1  read strobe. Data is returned on i_mem_rdata on the next cycle.
- o_mem_we  out  1  write strobe. Write occurs at this clock edge.
- o_mem_wdata  out  DATA_WIDTH  write data (always A).
- i_mem_rdata  in  DATA_WIDTH  read data, 1-cycle latency after o_mem_re.
- o_out  out  DATA_WIDTH  output register.
- o_out_valid  out  1  one-cycle pulse when o_out is loaded.
- o_flag_c  out  1  carry / no-borrow flag.
- o_flag_z  out  1  zero flag.
- o_halted  out  1  high while in the HALTED state.

Behaviour:
- Reset (synchronous, wins over i_enable):
  - PC, A, B, IR, flags, o_out cleared to 0.
  - o_out_valid = 0, o_halted = 0, o_mem_re = 0, o_mem_we = 0.
  - State goes to FETCH.
  - Reset asserted mid-instruction aborts the instruction; no memory write occurs in the reset cycle.
- Instruction format:
  - opcode = IR[DATA_WIDTH-1 -: 4]
  - arg = IR[ADDR_WIDTH-1:0]
  - Remaining middle bits are ignored.
- Opcodes:
  - 0 NOP
  - 1 LDA arg: A = mem[arg]
  - 2 ADD arg: A = A + mem[arg]
  - 3 SUB arg: A = A - mem[arg]
  - 4 STA arg: mem[arg] = A
  - 5 LDI arg: A = zero-extended arg
  - 6 JMP arg
  - 7 JC arg: jump if C = 1
  - 8 JZ arg: jump if Z = 1
  - 9 to D: NOP
  - E OUT: o_out = A, pulse o_out_valid
  - F HLT
- FSM states: FETCH, LOAD_IR, DECODE, MEM_WAIT, EXEC, HALTED. Each transition takes one enabled cycle.
  - FETCH: o_mem_addr = PC, o_mem_re = 1. Next state LOAD_IR.
  - LOAD_IR: IR = i_mem_rdata; PC = PC + 1, modulo 2^ADDR_WIDTH (15 wraps to 0). Next state DECODE.
  - DECODE:
    - LDA/ADD/SUB: o_mem_addr = arg, o_mem_re = 1. Next state MEM_WAIT.
    - STA: o_mem_addr = arg, o_mem_we = 1, o_mem_wdata = A. Next state FETCH.
    - LDI, and JMP/JC/JZ (PC = arg when taken, else PC unchanged): next state FETCH.
    - OUT: o_out = A and o_out_valid = 1 for the cycle after this edge. Next state FETCH.
    - HLT: next state HALTED.
    - NOP and unused opcodes: next state FETCH.
  - MEM_WAIT:
    - LDA: A = i_mem_rdata. Next state FETCH.
    - ADD/SUB: B = i_mem_rdata. Next state EXEC.
  - EXEC:
    - ADD: {C, A} = A + B (C is the carry-out).
    - SUB: A = A - B modulo 2^DATA_WIDTH; C = (A >= B) unsigned, i.e. no borrow.
    - Both: Z = (new A == 0). Next state FETCH.
  - HALTED: o_halted = 1, no memory strobes. Left only by reset.
- Flags change only in EXEC. LDA and LDI leave C and Z unchanged.
- Latency in enabled cycles:
  - NOP, LDI, JMP, JC, JZ, STA, OUT, HLT: 3
  - LDA: 4
  - ADD, SUB: 5
- i_enable = 0:
  - Freezes state, all registers and o_out; o_mem_re = o_mem_we = 0.
  - o_out_valid forced 0; a pending pulse is emitted on the first cycle enable returns.
  - Read data is re-requested: the read strobe re-asserts once enable returns, so stalls inside FETCH or DECODE do not lose read data.
  - Stalling in LOAD_IR or MEM_WAIT requires the memory to hold i_mem_rdata stable. The RAM holds its output when o_mem_re = 0.
- All outputs are driven from registers or from state/register decode. There is no combinational path from i_mem_rdata to any output.

Test Plan:
- Add program: mem[0..3] = 0x1E, 0x2F, 0xE0, 0xF0; mem[14] = 0x1C, mem[15] = 0x0E; reset then enable -> o_out = 0x2A with a single o_out_valid pulse; C = 0, Z = 0; o_halted rises after exactly 15 enabled cycles and stays high.
- Sub borrow: 0x55 (LDI 5), 0x3F (SUB 15), 0x7x (JC, not taken), 0xE0, 0xF0 with mem[15] = 0x07 -> o_out = 0xFE, C = 0, Z = 0; fall-through path taken.
- Zero jump: LDI 3, SUB 15 (mem[15] = 3), JZ 6, then HLT at 3, OUT/HLT at 6 -> A = 0, Z = 1, C = 1; jump taken; o_out = 0x00 with valid pulse, then halted.
- STA and PC wrap: LDI 9, STA 13, NOPs up to address 15, JMP at 15 not used (NOP) -> mem[13] = 0x09 written with one we pulse; PC wraps 15 -> 0 and re-executes LDI.
- Enable stall: deassert i_enable for 4 cycles inside ADD's MEM_WAIT and again during the OUT cycle -> no strobes while low, same final o_out = 0x2A, cycle count extended by exactly 4 per stall.
- Reset mid-ADD (in EXEC) and while HALTED -> all outputs return to reset values in the next cycle; no memory write; execution restarts at address 0.
